// File: rtl/if_id_pipe.sv
// ---------------------------------------------------------------------------
// if_id_pipe
// Fetch/decode pipeline register for the WISC-SP20 5-stage pipeline.
// Latches the fetched instruction and PC+2 for decode, injects NOP bubbles
// on flush or missing fetch data, holds on a decode stall, and freezes fetch
// once a HALT has advanced past IF/ID. Saturating stall and flush event
// counters are kept for performance debug.
//
// Ports:
//   clk           system clock, rising-edge active
//   rst           asynchronous, active-high reset
//   ins_in        instruction word from instruction memory
//   pc_plus2_in   PC+2 computed in fetch
//   fetch_valid   instruction memory returned a valid word this cycle
//   stall_decode  hold IF/ID contents (hazard detection)
//   flush_fetch   squash IF/ID contents (redirect resolved)
//   ins_out       instruction presented to decode
//   pc_plus2_out  PC+2 presented to decode
//   valid_out     ins_out is a real instruction, not a bubble
//   stall_fetch   PC write disable to fetch (combinational)
//   halted        HALT has advanced past IF/ID; fetch frozen
//   stall_cnt     cycles a valid instruction was held by stall_decode
//   flush_cnt     flush_fetch events
// ---------------------------------------------------------------------------
module if_id_pipe #(
    parameter int          CNT_W   = 16,
    parameter logic [15:0] NOP_INS = 16'h0800,
    parameter logic [4:0]  HALT_OP = 5'b00000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      ins_in,
    input  logic [15:0]      pc_plus2_in,
    input  logic             fetch_valid,
    input  logic             stall_decode,
    input  logic             flush_fetch,
    output logic [15:0]      ins_out,
    output logic [15:0]      pc_plus2_out,
    output logic             valid_out,
    output logic             stall_fetch,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t             state_r;
    logic [15:0]        ins_r;
    logic [15:0]        pc_plus2_r;
    logic               valid_r;
    logic               halted_r;
    logic [CNT_W-1:0]   stall_cnt_r;
    logic [CNT_W-1:0]   flush_cnt_r;
    logic               halt_in_ifid_s;
    logic               stall_event_s;

    // Saturating increment: an all-ones counter stays at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] one;
        one = {{(CNT_W-1){1'b0}}, 1'b1};
        if (v == {CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + one;
        end
    endfunction

    // A real HALT sitting in IF/ID; it leaves on the next unstalled, unflushed edge.
    assign halt_in_ifid_s = valid_r & (ins_r[15:11] == HALT_OP);

    // Only a real instruction held by the hazard unit counts as a stall cycle.
    assign stall_event_s = (state_r == ST_RUN) & valid_r & stall_decode & ~flush_fetch;

    // Flush always releases the PC so the redirect target gets written.
    assign stall_fetch = ~flush_fetch & (stall_decode | halted_r);

    // Pipeline register, HALT state machine and event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_RUN;
            ins_r       <= NOP_INS;
            pc_plus2_r  <= 16'h0000;
            valid_r     <= 1'b0;
            halted_r    <= 1'b0;
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (flush_fetch) begin
                flush_cnt_r <= sat_inc(flush_cnt_r);
            end
            if (stall_event_s) begin
                stall_cnt_r <= sat_inc(stall_cnt_r);
            end

            case (state_r)
                ST_RUN: begin
                    if (flush_fetch) begin
                        ins_r      <= NOP_INS;
                        valid_r    <= 1'b0;
                        pc_plus2_r <= pc_plus2_in;
                    end else if (stall_decode) begin
                        ins_r      <= ins_r;
                        valid_r    <= valid_r;
                        pc_plus2_r <= pc_plus2_r;
                    end else if (halt_in_ifid_s) begin
                        // HALT moves into ID/EX; nothing younger may follow it.
                        ins_r      <= NOP_INS;
                        valid_r    <= 1'b0;
                        pc_plus2_r <= pc_plus2_in;
                        state_r    <= ST_HALTED;
                        halted_r   <= 1'b1;
                    end else if (fetch_valid) begin
                        ins_r      <= ins_in;
                        valid_r    <= 1'b1;
                        pc_plus2_r <= pc_plus2_in;
                    end else begin
                        ins_r      <= NOP_INS;
                        valid_r    <= 1'b0;
                        pc_plus2_r <= pc_plus2_in;
                    end
                end
                ST_HALTED: begin
                    ins_r   <= NOP_INS;
                    valid_r <= 1'b0;
                    if (flush_fetch) begin
                        // An older branch redirected; the HALT is squashed downstream.
                        pc_plus2_r <= pc_plus2_in;
                        state_r    <= ST_RUN;
                        halted_r   <= 1'b0;
                    end else begin
                        pc_plus2_r <= pc_plus2_r;
                    end
                end
                default: begin
                    state_r  <= ST_RUN;
                    halted_r <= 1'b0;
                    ins_r    <= NOP_INS;
                    valid_r  <= 1'b0;
                end
            endcase
        end
    end

    assign ins_out      = ins_r;
    assign pc_plus2_out = pc_plus2_r;
    assign valid_out    = valid_r;
    assign halted       = halted_r;
    assign stall_cnt    = stall_cnt_r;
    assign flush_cnt    = flush_cnt_r;

endmodule

// File: tb/tb_if_id_pipe.sv
module tb_if_id_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ins_in;
    logic [15:0] pc_plus2_in;
    logic        fetch_valid;
    logic        stall_decode;
    logic        flush_fetch;

    logic [15:0] ins_out, pc_plus2_out;
    logic        valid_out, stall_fetch, halted;
    logic [15:0] stall_cnt, flush_cnt;

    // Narrow-counter copy sharing the same stimulus, used for saturation.
    logic [15:0] n_ins_out, n_pc_plus2_out;
    logic        n_valid_out, n_stall_fetch, n_halted;
    logic [1:0]  n_stall_cnt, n_flush_cnt;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic [15:0] ins;
        logic [15:0] pc;
        logic        v;
        logic        h;
        logic        sf;
        logic [15:0] sc;
        logic [15:0] fc;
        bit          chk_pc;
        int          idx;
    } exp_t;

    exp_t exp_q[$];
    int   step_no = 0;

    always #5 clk = ~clk;

    if_id_pipe #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .ins_in(ins_in), .pc_plus2_in(pc_plus2_in),
        .fetch_valid(fetch_valid), .stall_decode(stall_decode), .flush_fetch(flush_fetch),
        .ins_out(ins_out), .pc_plus2_out(pc_plus2_out), .valid_out(valid_out),
        .stall_fetch(stall_fetch), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    if_id_pipe #(.CNT_W(2)) dut_narrow (
        .clk(clk), .rst(rst), .ins_in(ins_in), .pc_plus2_in(pc_plus2_in),
        .fetch_valid(fetch_valid), .stall_decode(stall_decode), .flush_fetch(flush_fetch),
        .ins_out(n_ins_out), .pc_plus2_out(n_pc_plus2_out), .valid_out(n_valid_out),
        .stall_fetch(n_stall_fetch), .halted(n_halted),
        .stall_cnt(n_stall_cnt), .flush_cnt(n_flush_cnt)
    );

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    function automatic logic [15:0] sat2(input logic [15:0] v);
        return (v > 16'd3) ? 16'd3 : v;
    endfunction

    // Issue one cycle of stimulus and queue the outputs expected after the edge.
    task automatic step(input logic [15:0] i, input logic [15:0] p, input logic fv,
                        input logic st, input logic fl,
                        input logic [15:0] ei, input logic [15:0] ep, input logic ev,
                        input logic eh, input logic esf,
                        input logic [15:0] esc, input logic [15:0] efc, input bit cpc);
        exp_t e;
        @(negedge clk);
        ins_in = i; pc_plus2_in = p; fetch_valid = fv; stall_decode = st; flush_fetch = fl;
        step_no++;
        e.ins = ei; e.pc = ep; e.v = ev; e.h = eh; e.sf = esf;
        e.sc = esc; e.fc = efc; e.chk_pc = cpc; e.idx = step_no;
        exp_q.push_back(e);
    endtask

    // Monitor: after every active edge, pop the pending expectation and compare.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ins_out",      e.idx, ins_out, e.ins);
            if (e.chk_pc) chk("pc_plus2_out", e.idx, pc_plus2_out, e.pc);
            chk("valid_out",    e.idx, {15'd0, valid_out}, {15'd0, e.v});
            chk("halted",       e.idx, {15'd0, halted}, {15'd0, e.h});
            chk("stall_fetch",  e.idx, {15'd0, stall_fetch}, {15'd0, e.sf});
            chk("stall_cnt",    e.idx, stall_cnt, e.sc);
            chk("flush_cnt",    e.idx, flush_cnt, e.fc);
            chk("sat_stall_cnt", e.idx, {14'd0, n_stall_cnt}, sat2(e.sc));
            chk("sat_flush_cnt", e.idx, {14'd0, n_flush_cnt}, sat2(e.fc));
        end
    end

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ins"},   0, ins_out, 16'h0800);
        chk({tag, "_pc"},    0, pc_plus2_out, 16'h0000);
        chk({tag, "_valid"}, 0, {15'd0, valid_out}, 16'd0);
        chk({tag, "_halt"},  0, {15'd0, halted}, 16'd0);
        chk({tag, "_sf"},    0, {15'd0, stall_fetch}, 16'd0);
        chk({tag, "_sc"},    0, stall_cnt, 16'd0);
        chk({tag, "_fc"},    0, flush_cnt, 16'd0);
        chk({tag, "_nsc"},   0, {14'd0, n_stall_cnt}, 16'd0);
    endtask

    initial begin
        int wait_cnt;
        rst = 1'b1;
        ins_in = 16'h0000; pc_plus2_in = 16'h0000;
        fetch_valid = 1'b0; stall_decode = 1'b0; flush_fetch = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk_reset_state("reset");
        @(negedge clk);
        rst = 1'b0;

        //    ins_in    pc     fv    st    fl     ins_out   pc_out v    h     sf    sc     fc   chkpc
        step(16'h4123, 16'h0002, 1'b1, 1'b0, 1'b0, 16'h4123, 16'h0002, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 1'b1);
        step(16'h5A01, 16'h0004, 1'b1, 1'b0, 1'b0, 16'h5A01, 16'h0004, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 1'b1);
        step(16'h6B02, 16'h0006, 1'b1, 1'b0, 1'b0, 16'h6B02, 16'h0006, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 1'b1);
        step(16'h4123, 16'h0008, 1'b1, 1'b0, 1'b0, 16'h4123, 16'h0008, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 1'b1);
        // three stalled cycles holding 4123
        for (int k = 1; k <= 3; k++) begin
            step(16'h7777, 16'h000A, 1'b1, 1'b1, 1'b0, 16'h4123, 16'h0008, 1'b1, 1'b0, 1'b1, 16'(k), 16'd0, 1'b1);
        end
        step(16'h7777, 16'h000A, 1'b1, 1'b0, 1'b0, 16'h7777, 16'h000A, 1'b1, 1'b0, 1'b0, 16'd3, 16'd0, 1'b1);
        // flush beats stall; valid stalled instruction is not counted
        step(16'h1234, 16'h000C, 1'b1, 1'b1, 1'b1, 16'h0800, 16'h000C, 1'b0, 1'b0, 1'b0, 16'd3, 16'd1, 1'b1);
        // two missing fetches, then a stall on the bubble
        step(16'h5555, 16'h000E, 1'b0, 1'b0, 1'b0, 16'h0800, 16'h000E, 1'b0, 1'b0, 1'b0, 16'd3, 16'd1, 1'b1);
        step(16'h5555, 16'h0010, 1'b0, 1'b0, 1'b0, 16'h0800, 16'h0010, 1'b0, 1'b0, 1'b0, 16'd3, 16'd1, 1'b1);
        step(16'h5555, 16'h0012, 1'b0, 1'b1, 1'b0, 16'h0800, 16'h0010, 1'b0, 1'b0, 1'b1, 16'd3, 16'd1, 1'b1);
        // HALT enters IF/ID, is stalled once, then advances
        step(16'h0000, 16'h0014, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0014, 1'b1, 1'b0, 1'b0, 16'd3, 16'd1, 1'b1);
        step(16'h4444, 16'h0016, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0014, 1'b1, 1'b0, 1'b1, 16'd4, 16'd1, 1'b1);
        step(16'h4444, 16'h0016, 1'b1, 1'b0, 1'b0, 16'h0800, 16'h0016, 1'b0, 1'b1, 1'b1, 16'd4, 16'd1, 1'b1);
        for (int k = 0; k < 10; k++) begin
            step(16'h4444, 16'h0018, 1'b1, 1'b0, 1'b0, 16'h0800, 16'h0000, 1'b0, 1'b1, 1'b1, 16'd4, 16'd1, 1'b0);
        end
        // redirect releases HALTED
        step(16'h4444, 16'h0020, 1'b1, 1'b0, 1'b1, 16'h0800, 16'h0020, 1'b0, 1'b0, 1'b0, 16'd4, 16'd2, 1'b1);
        step(16'h5A01, 16'h0022, 1'b1, 1'b0, 1'b0, 16'h5A01, 16'h0022, 1'b1, 1'b0, 1'b0, 16'd4, 16'd2, 1'b1);
        // HALT again to get back into HALTED before the async reset
        step(16'h0000, 16'h0024, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0024, 1'b1, 1'b0, 1'b0, 16'd4, 16'd2, 1'b1);
        step(16'h4444, 16'h0026, 1'b1, 1'b0, 1'b0, 16'h0800, 16'h0026, 1'b0, 1'b1, 1'b1, 16'd4, 16'd2, 1'b1);
        step(16'h4444, 16'h0028, 1'b1, 1'b1, 1'b0, 16'h0800, 16'h0000, 1'b0, 1'b1, 1'b1, 16'd4, 16'd2, 1'b0);

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 5) begin
            @(posedge clk);
            wait_cnt++;
        end
        #2;
        n_total++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        // async reset mid-HALTED, checked between clock edges
        @(negedge clk);
        stall_decode = 1'b0; flush_fetch = 1'b0; fetch_valid = 1'b0;
        #2 rst = 1'b1;
        #1 chk_reset_state("async_rst");
        @(negedge clk);
        rst = 1'b0;
        step(16'h1111, 16'h0030, 1'b1, 1'b0, 1'b0, 16'h1111, 16'h0030, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 1'b1);
        @(posedge clk);
        #3;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
